// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC sampler.
// Contents: FSM state encoding, default sample width, frame-length helper.
package adc_pkg;

   localparam int unsigned ADC_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } adc_state_t;

   // Clock cycles from chip-select fall to chip-select rise for one frame.
   function automatic int unsigned frame_cycles(input int unsigned sclk_div,
                                                input int unsigned frame_bits);
      return 1 + sclk_div + 2 * sclk_div * frame_bits;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock divider for the ADC link.
// Ports:
//   i_clk, i_rst   system clock, async active-high reset
//   i_en           run the divider (SETUP/SHIFT); low forces sclk low and clears the count
//   i_hold         frame finished: suppress the next low->high toggle
//   o_sclk         serial clock, idle low, half-period SCLK_DIV cycles
//   o_rise_tick    high in the first cycle sclk is high
//   o_fall_tick    high in the first cycle sclk is low again
//   o_wrap_c       combinational: a half-period ends at this clock edge
module spi_clk_gen
   import adc_pkg::*;
#(
   parameter int unsigned SCLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_hold,
   output logic o_sclk,
   output logic o_rise_tick,
   output logic o_fall_tick,
   output logic o_wrap_c
);

   localparam int unsigned DIV_W = $clog2(SCLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic             r_sclk;
   logic             r_rise_tick;
   logic             r_fall_tick;
   logic             w_wrap;
   logic             w_toggle;

   assign w_wrap   = i_en && (r_div == DIV_LAST);
   // The final low half-period still runs its full length but must not start a new pulse.
   assign w_toggle = w_wrap && !(i_hold && !r_sclk);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div       <= '0;
         r_sclk      <= 1'b0;
         r_rise_tick <= 1'b0;
         r_fall_tick <= 1'b0;
      end else if (!i_en) begin
         r_div       <= '0;
         r_sclk      <= 1'b0;
         r_rise_tick <= 1'b0;
         r_fall_tick <= 1'b0;
      end else begin
         r_rise_tick <= 1'b0;
         r_fall_tick <= 1'b0;
         if (w_wrap) r_div <= '0;
         else        r_div <= r_div + DIV_W'(1);
         if (w_toggle) begin
            r_sclk      <= ~r_sclk;
            r_rise_tick <= ~r_sclk;
            r_fall_tick <= r_sclk;
         end
      end
   end

   assign o_sclk      = r_sclk;
   assign o_rise_tick = r_rise_tick;
   assign o_fall_tick = r_fall_tick;
   assign o_wrap_c    = w_wrap;

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic sampler for an 8-bit serial ADC feeding the moving-average filter.
// Ports:
//   clk, reset     system clock, async active-high reset
//   enable_i       allows new conversions to start
//   ready_i        downstream accepts a strobe this cycle
//   clear_ovr_i    clears overrun_o (wins over a simultaneous drop)
//   miso_i         ADC serial data
//   cs_n_o, sclk_o ADC chip select (active low) and serial clock (idle low)
//   data_o         last accepted sample, strobe_o one-cycle valid pulse
//   busy_o         frame in progress, overrun_o sticky dropped-sample flag
module adc_spi_sampler
   import adc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = ADC_DATA_WIDTH,
   parameter int unsigned FRAME_BITS    = 16,
   parameter int unsigned LEAD_BITS     = 3,
   parameter int unsigned SCLK_DIV      = 4,
   parameter int unsigned SAMPLE_PERIOD = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable_i,
   input  logic                  ready_i,
   input  logic                  clear_ovr_i,
   input  logic                  miso_i,
   output logic                  cs_n_o,
   output logic                  sclk_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  strobe_o,
   output logic                  busy_o,
   output logic                  overrun_o
);

   localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);
   localparam int unsigned TMR_W = $clog2(SAMPLE_PERIOD);
   localparam logic [BIT_W-1:0] BIT_FULL   = BIT_W'(FRAME_BITS);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(LEAD_BITS);
   localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(LEAD_BITS + DATA_WIDTH - 1);
   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SAMPLE_PERIOD - 1);

   if (DATA_WIDTH == 0) begin : g_bad_width
      $error("adc_spi_sampler: DATA_WIDTH must be at least 1");
   end
   if (LEAD_BITS + DATA_WIDTH > FRAME_BITS) begin : g_bad_frame
      $error("adc_spi_sampler: LEAD_BITS + DATA_WIDTH exceeds FRAME_BITS");
   end
   if (SCLK_DIV == 0) begin : g_bad_div
      $error("adc_spi_sampler: SCLK_DIV must be at least 1");
   end
   if (SAMPLE_PERIOD < 2) begin : g_bad_period
      $error("adc_spi_sampler: SAMPLE_PERIOD must be at least 2");
   end

   adc_state_t            r_state;
   logic [TMR_W-1:0]      r_timer;
   logic                  r_pending;
   logic [BIT_W-1:0]      r_bit;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_cs_n;
   logic                  r_strobe;
   logic                  r_busy;
   logic                  r_ovr;

   logic w_clk_en;
   logic w_sclk;
   logic w_rise_tick;
   logic w_fall_tick;
   logic w_wrap;
   logic w_final;
   logic w_start;
   logic w_tmr_wrap;

   assign w_clk_en   = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
   assign w_start    = (r_state == ST_IDLE) && r_pending && enable_i;
   assign w_tmr_wrap = enable_i && (r_timer == TMR_LAST);
   // All sclk periods have completed; the fall tick term covers SCLK_DIV=1,
   // where the last low half-period is the fall-tick cycle itself.
   assign w_final    = (r_bit == BIT_FULL) || (w_fall_tick && (r_bit == BIT_LAST));

   spi_clk_gen #(
      .SCLK_DIV (SCLK_DIV)
   ) u_clk_gen (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_en        (w_clk_en),
      .i_hold      (w_final),
      .o_sclk      (w_sclk),
      .o_rise_tick (w_rise_tick),
      .o_fall_tick (w_fall_tick),
      .o_wrap_c    (w_wrap)
   );

   // Conversion period timer; wraps collapse into one pending start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer   <= '0;
         r_pending <= 1'b0;
      end else begin
         if (!enable_i || r_timer == TMR_LAST) r_timer <= '0;
         else                                  r_timer <= r_timer + TMR_W'(1);
         if (w_tmr_wrap)   r_pending <= 1'b1;
         else if (w_start) r_pending <= 1'b0;
      end
   end

   // Frame sequencing, serial capture and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_bit    <= '0;
         r_shift  <= '0;
         r_data   <= '0;
         r_cs_n   <= 1'b1;
         r_strobe <= 1'b0;
         r_busy   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state <= ST_SETUP;
                  r_cs_n  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_bit   <= '0;
                  r_shift <= '0;
               end
            end
            ST_SETUP: begin
               if (w_wrap) r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // r_bit counts completed sclk periods, so it is the index of the bit being sampled.
               if (w_rise_tick && r_bit >= DATA_FIRST && r_bit <= DATA_LAST)
                  r_shift <= DATA_WIDTH'({r_shift, miso_i});
               if (w_fall_tick) r_bit <= r_bit + BIT_W'(1);
               if (w_wrap && w_final && !w_sclk) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
               r_bit   <= '0;
               if (ready_i) begin
                  r_data   <= r_shift;
                  r_strobe <= 1'b1;
               end else begin
                  r_ovr <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         if (clear_ovr_i) r_ovr <= 1'b0;
      end
   end

   assign cs_n_o    = r_cs_n;
   assign sclk_o    = w_sclk;
   assign data_o    = r_data;
   assign strobe_o  = r_strobe;
   assign busy_o    = r_busy;
   assign overrun_o = r_ovr;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler: frame vector table plus corner-case sequences.
module tb_adc_spi_sampler;

   localparam int unsigned FRAME_LEN = 67;   // 1 + 2 + 2*2*16 with SCLK_DIV=2, FRAME_BITS=16

   logic       clk;
   logic       reset;
   logic       enable;
   logic       ready;
   logic       clear_ovr;
   logic       miso;
   logic       cs_n, sclk, strobe, busy, ovr;
   logic [7:0] data;
   logic       f_cs_n, f_sclk, f_strobe, f_busy, f_ovr;
   logic [7:0] f_data;

   int checks;
   int errors;
   int cyc;

   adc_spi_sampler #(
      .DATA_WIDTH (8), .FRAME_BITS (16), .LEAD_BITS (3), .SCLK_DIV (2), .SAMPLE_PERIOD (100)
   ) u_dut (
      .clk (clk), .reset (reset), .enable_i (enable), .ready_i (ready),
      .clear_ovr_i (clear_ovr), .miso_i (miso), .cs_n_o (cs_n), .sclk_o (sclk),
      .data_o (data), .strobe_o (strobe), .busy_o (busy), .overrun_o (ovr)
   );

   // Short-period instance: conversion requests arrive faster than frames complete.
   adc_spi_sampler #(
      .DATA_WIDTH (8), .FRAME_BITS (16), .LEAD_BITS (3), .SCLK_DIV (2), .SAMPLE_PERIOD (20)
   ) u_dut_fast (
      .clk (clk), .reset (reset), .enable_i (1'b1), .ready_i (1'b1),
      .clear_ovr_i (1'b0), .miso_i (1'b1), .cs_n_o (f_cs_n), .sclk_o (f_sclk),
      .data_o (f_data), .strobe_o (f_strobe), .busy_o (f_busy), .overrun_o (f_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // ADC model: 16-bit frame word, bit k presented after the k-th sclk rise (MSB first).
   logic [15:0] adc_word;
   int          rise_cnt;
   always @(negedge cs_n) rise_cnt = 0;
   always @(posedge sclk) rise_cnt = rise_cnt + 1;
   always_comb begin
      miso = 1'b0;
      if (rise_cnt >= 1 && rise_cnt <= 16) miso = adc_word[4'(16 - rise_cnt)];
   end

   // Garbage in the lead and trail bits so a misplaced capture window shows up.
   function automatic logic [15:0] mk(input logic [7:0] d);
      return {3'b101, d, 5'b11011};
   endfunction

   // Observers, sampled on the falling clock edge.
   int   low_cnt, last_low, last_rises, fall_cnt, consec;
   logic prev_cs, prev_stb;
   int   f_hi, f_frames, f_consec;
   logic f_prev_cs, f_prev_stb;
   int   f_stb_q[$];
   int   f_hi_q[$];

   always @(negedge clk) begin
      if (reset) begin
         low_cnt = 0; prev_cs = 1'b1; prev_stb = 1'b0;
         f_hi = 0; f_frames = 0; f_prev_cs = 1'b1; f_prev_stb = 1'b0;
         f_stb_q.delete(); f_hi_q.delete();
      end else begin
         if (!cs_n) low_cnt = low_cnt + 1;
         if (!cs_n && prev_cs) fall_cnt = fall_cnt + 1;
         if (cs_n && !prev_cs) begin
            last_low = low_cnt; last_rises = rise_cnt; low_cnt = 0;
         end
         if (strobe && prev_stb) consec = consec + 1;
         prev_cs = cs_n; prev_stb = strobe;

         if (f_cs_n) f_hi = f_hi + 1;
         if (!f_cs_n && f_prev_cs) begin
            if (f_frames > 0) f_hi_q.push_back(f_hi);
            f_frames = f_frames + 1;
            f_hi = 0;
         end
         if (f_strobe) f_stb_q.push_back(cyc);
         if (f_strobe && f_prev_stb) f_consec = f_consec + 1;
         f_prev_cs = f_cs_n; f_prev_stb = f_strobe;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cs(input logic lvl, input int limit, input string what);
      int n;
      n = 0;
      while (cs_n !== lvl && n < limit) begin
         tick();
         n++;
      end
      if (cs_n !== lvl) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s timeout: cs_n=%0b expected %0b", what, cs_n, lvl);
      end
   endtask

   task automatic wait_rises(input int target, input string what);
      int n;
      n = 0;
      while (rise_cnt < target && n < 200) begin
         tick();
         n++;
      end
      if (rise_cnt < target) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s timeout: rises=%0d expected %0d", what, rise_cnt, target);
      end
   endtask

   typedef struct {
      logic [7:0] sample;
      logic       rdy;
      logic [7:0] exp_data;
      logic       exp_strobe;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      int prev_stb_cyc;
      bit have_prev;

      vecs[0] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
      vecs[3] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
      vecs[4] = '{8'h33, 1'b0, 8'h5A, 1'b0, 1'b1};

      checks = 0; errors = 0; cyc = 0; fall_cnt = 0; consec = 0; f_consec = 0;
      last_low = 0; last_rises = 0; rise_cnt = 0;
      reset = 1'b1; enable = 1'b0; ready = 1'b1; clear_ovr = 1'b0; adc_word = '0;
      repeat (3) tick();

      chk("rst_cs_n",   32'(cs_n),   32'd1);
      chk("rst_sclk",   32'(sclk),   32'd0);
      chk("rst_data",   32'(data),   32'd0);
      chk("rst_strobe", 32'(strobe), 32'd0);
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_ovr",    32'(ovr),    32'd0);

      reset = 1'b0;

      // Disabled: no chip-select activity at all.
      f0 = fall_cnt;
      repeat (1000) tick();
      chk("disabled_no_frames", 32'(fall_cnt - f0), 32'd0);

      // Short period instance ran during that window.
      chk("fast_enough_strobes", 32'(f_stb_q.size() >= 10), 32'd1);
      for (int i = 1; i <= 5 && i < f_stb_q.size(); i++)
         chk("fast_strobe_spacing", 32'(f_stb_q[i] - f_stb_q[i-1]), 32'(FRAME_LEN + 1));
      for (int i = 0; i < 4 && i < f_hi_q.size(); i++)
         chk("fast_cs_high_gap", 32'(f_hi_q[i]), 32'd1);
      chk("fast_data", 32'(f_data), 32'hFF);

      // Table-driven frames.
      enable = 1'b1;
      have_prev = 1'b0;
      prev_stb_cyc = 0;
      for (int i = 0; i < 5; i++) begin
         wait_cs(1'b0, 300, "row_start");
         adc_word = mk(vecs[i].sample);
         ready    = vecs[i].rdy;
         wait_cs(1'b1, 100, "row_end");
         chk("row_data",    32'(data),   32'(vecs[i].exp_data));
         chk("row_strobe",  32'(strobe), 32'(vecs[i].exp_strobe));
         chk("row_ovr",     32'(ovr),    32'(vecs[i].exp_ovr));
         chk("row_cs_low",  32'(last_low),   32'(FRAME_LEN));
         chk("row_sclk_rises", 32'(last_rises), 32'd16);
         if (vecs[i].exp_strobe) begin
            if (have_prev) chk("row_strobe_spacing", 32'(cyc - prev_stb_cyc), 32'd100);
            prev_stb_cyc = cyc;
            have_prev = 1'b1;
         end
         tick();
         chk("row_strobe_one_cycle", 32'(strobe), 32'd0);
      end
      ready = 1'b1;

      // Clear pulse on a set overrun flag.
      clear_ovr = 1'b1;
      tick();
      clear_ovr = 1'b0;
      chk("ovr_cleared", 32'(ovr), 32'd0);

      // Clear coincides with a new drop in the DONE cycle.
      wait_cs(1'b0, 300, "simul_start");
      adc_word = mk(8'h44);
      ready = 1'b0;
      repeat (FRAME_LEN - 1) tick();
      clear_ovr = 1'b1;
      tick();
      clear_ovr = 1'b0;
      chk("simul_cs_high",  32'(cs_n),   32'd1);
      chk("simul_ovr",      32'(ovr),    32'd0);
      chk("simul_strobe",   32'(strobe), 32'd0);
      chk("simul_data_kept", 32'(data),  32'h5A);
      ready = 1'b1;

      // Reset in the middle of a frame.
      wait_cs(1'b0, 300, "rst_mid_start");
      adc_word = mk(8'hE7);
      wait_rises(5, "rst_mid_rises");
      reset = 1'b1;
      #1;
      chk("midrst_cs_n",   32'(cs_n),   32'd1);
      chk("midrst_sclk",   32'(sclk),   32'd0);
      chk("midrst_strobe", 32'(strobe), 32'd0);
      chk("midrst_busy",   32'(busy),   32'd0);
      tick();
      reset = 1'b0;
      wait_cs(1'b0, 300, "post_rst_start");
      adc_word = mk(8'hC3);
      wait_cs(1'b1, 100, "post_rst_end");
      chk("post_rst_data",   32'(data),     32'hC3);
      chk("post_rst_strobe", 32'(strobe),   32'd1);
      chk("post_rst_cs_low", 32'(last_low), 32'(FRAME_LEN));

      // Enable dropped mid-frame: frame completes, nothing follows.
      wait_cs(1'b0, 300, "en_drop_start");
      adc_word = mk(8'h6E);
      wait_rises(8, "en_drop_rises");
      enable = 1'b0;
      wait_cs(1'b1, 100, "en_drop_end");
      chk("en_drop_data",   32'(data),   32'h6E);
      chk("en_drop_strobe", 32'(strobe), 32'd1);
      f0 = fall_cnt;
      repeat (500) tick();
      chk("en_drop_no_more_frames", 32'(fall_cnt - f0), 32'd0);

      chk("no_back_to_back_strobe",      32'(consec),   32'd0);
      chk("fast_no_back_to_back_strobe", 32'(f_consec), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
